// File: rtl/seven_segment_mux_ctrl_if.sv
// seven_segment_mux_ctrl_if: value/control inputs and scan outputs of the seven-segment controller
interface seven_segment_mux_ctrl_if #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W = 27
);
  logic [DATA_W-1:0] in_data;
  logic out_of_range;
  logic [NUM_DIGITS-1:0] dp_mask;
  logic [NUM_DIGITS-1:0] anode;
  logic [7:0] select_seg;
  logic conv_done;
  modport master (output in_data, out_of_range, dp_mask, input anode, select_seg, conv_done);
  modport slave (input in_data, out_of_range, dp_mask, output anode, select_seg, conv_done);
endinterface

// File: rtl/seven_segment_mux_ctrl.sv
// seven_segment_mux_ctrl: double-dabble binary-to-BCD converter plus multiplexed 7-segment scanner.
// Define SEG_LZ_BLANK_EN to blank leading zero digits.
module seven_segment_mux_ctrl #(
  parameter int NUM_DIGITS = 8,
  parameter int DATA_W = 27,
  parameter int DIGIT_PERIOD = 262144
) (
  input logic clk,
  input logic rst,
  seven_segment_mux_ctrl_if.slave bus
);
  localparam int BW = 4 * NUM_DIGITS + 4;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = $clog2(DIGIT_PERIOD);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] CMAX = CW'(DATA_W - 1);
  localparam logic [PW-1:0] PMAX = PW'(DIGIT_PERIOD - 1);
  localparam logic [IW-1:0] IMAX = IW'(NUM_DIGITS - 1);
  localparam logic [IW-1:0] D2 = IW'(2);
  localparam logic [7:0] SEG_E = 8'b01100001;
  localparam logic [7:0] SEG_R = 8'b11110101;
  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BW-1:0] bcd_q, bcd_d, bcd_adj;
  logic ovf_q, ovf_d, oor_q, oor_d, err_q, err_d, done_q, done_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d, lz;
  logic [7:0] seg_q, seg_d, glyph;
  logic [3:0] nib;
  logic nz;
  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'd0: enc = 8'b00000011;
      4'd1: enc = 8'b10011111;
      4'd2: enc = 8'b00100101;
      4'd3: enc = 8'b00001101;
      4'd4: enc = 8'b10011001;
      4'd5: enc = 8'b01001001;
      4'd6: enc = 8'b01000001;
      4'd7: enc = 8'b00011111;
      4'd8: enc = 8'b00000001;
      4'd9: enc = 8'b00001001;
      default: enc = 8'hFF;
    endcase
  endfunction
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i <= NUM_DIGITS; i++)
      bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] >= 4'd5 ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
  end
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bin_d = bin_q;
    bcd_d = bcd_q;
    ovf_d = ovf_q;
    oor_d = oor_q;
    err_d = err_q;
    disp_d = disp_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        bin_d = bus.in_data;
        oor_d = bus.out_of_range;
        bcd_d = '0;
        ovf_d = 1'b0;
        cnt_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
        // a carry out of the overflow nibble must still flag the error
        ovf_d = ovf_q | bcd_adj[BW-1];
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CMAX ? COMMIT : SHIFT;
      end
      COMMIT: begin
        err_d = oor_q | ovf_q | (bcd_q[BW-1 -: 4] != 4'd0);
        disp_d = bcd_q[4*NUM_DIGITS-1:0];
        done_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    lz = '0;
    nz = 1'b0;
`ifdef SEG_LZ_BLANK_EN
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      nz = nz | (disp_q[4*i +: 4] != 4'd0);
      lz[i] = ~nz;
    end
`endif
    presc_d = presc_q == PMAX ? '0 : presc_q + 1'b1;
    idx_d = presc_q == PMAX ? (idx_q == IMAX ? '0 : idx_q + 1'b1) : idx_q;
    anode_d = ~(NUM_DIGITS'(1) << idx_q);
    nib = disp_q[{idx_q, 2'b00} +: 4];
    glyph = err_q ? (idx_q == D2 ? SEG_E : idx_q < D2 ? SEG_R : 8'hFF) : lz[idx_q] ? 8'hFF : enc(nib);
    seg_d = {glyph[7:1], glyph[0] & ~bus.dp_mask[idx_q]};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
      oor_q <= 1'b0;
      err_q <= 1'b0;
      disp_q <= '0;
      done_q <= 1'b0;
      presc_q <= '0;
      idx_q <= '0;
      anode_q <= '1;
      seg_q <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      ovf_q <= ovf_d;
      oor_q <= oor_d;
      err_q <= err_d;
      disp_q <= disp_d;
      done_q <= done_d;
      presc_q <= presc_d;
      idx_q <= idx_d;
      anode_q <= anode_d;
      seg_q <= seg_d;
    end
  end
  assign bus.anode = anode_q;
  assign bus.select_seg = seg_q;
  assign bus.conv_done = done_q;
endmodule

// File: tb/tb_seven_segment_mux_ctrl.sv
// tb_seven_segment_mux_ctrl: directed tests of conversion, scanning, error, blanking and decimal points.
module tb_seven_segment_mux_ctrl;
  localparam int ND = 8;
  localparam int DW = 27;
  localparam int DP = 4;
  localparam logic [7:0] S [10] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101, 8'b10011001,
                                    8'b01001001, 8'b01000001, 8'b00011111, 8'b00000001, 8'b00001001};
  localparam logic [7:0] SE = 8'b01100001;
  localparam logic [7:0] SR = 8'b11110101;
  localparam logic [7:0] SB = 8'hFF;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  logic [7:0] got [ND];
  logic [7:0] e [ND];
  always #5 clk = ~clk;
  seven_segment_mux_ctrl_if #(.NUM_DIGITS(ND), .DATA_W(DW)) bus ();
  seven_segment_mux_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .DIGIT_PERIOD(DP)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      step();
      n++;
    end while (!bus.conv_done && n < 100);
    checks++;
    if (!bus.conv_done) begin
      errors++;
      $display("FAIL conv_done_timeout: no pulse after %0d cycles, required within 100", n);
    end
  endtask

  task automatic show(input logic [DW-1:0] v, input logic oor);
    bus.in_data = v;
    bus.out_of_range = oor;
    wait_done();
    wait_done();
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < ND; i++) got[i] = 8'h00;
    repeat (n) begin
      step();
      for (int i = 0; i < ND; i++)
        if (bus.anode == ~(ND'(1) << i)) got[i] = bus.select_seg;
    end
  endtask

  task automatic test_reset();
    int n = 0;
    rst = 1'b1;
    bus.in_data = '0;
    bus.out_of_range = 1'b0;
    bus.dp_mask = '0;
    repeat (3) step();
    checks += 3;
    if (bus.anode !== 8'hFF) begin errors++; $display("FAIL reset_anode: got %h expected ff", bus.anode); end
    if (bus.select_seg !== 8'hFF) begin errors++; $display("FAIL reset_seg: got %h expected ff", bus.select_seg); end
    if (bus.conv_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.conv_done); end
    rst = 1'b0;
    repeat (10) step();
    rst = 1'b1;
    repeat (3) begin
      step();
      checks += 2;
      if (bus.anode !== 8'hFF) begin errors++; $display("FAIL midreset_anode: got %h expected ff", bus.anode); end
      if (bus.select_seg !== 8'hFF) begin errors++; $display("FAIL midreset_seg: got %h expected ff", bus.select_seg); end
    end
    rst = 1'b0;
    do begin
      step();
      n++;
    end while (!bus.conv_done && n < 100);
    checks++;
    if (n != DW + 2) begin errors++; $display("FAIL first_done_latency: got %0d cycles expected %0d", n, DW + 2); end
    step();
    checks++;
    if (bus.conv_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width: got %b expected 0", bus.conv_done); end
  endtask

  task automatic test_value();
    show(27'd12345678, 1'b0);
    capture(40);
    e = '{S[8], S[7], S[6], S[5], S[4], S[3], S[2], S[1]};
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL value_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
  endtask

  task automatic test_scan();
    int prev = -1;
    int k;
    bit wrapped = 0;
    repeat (80) begin
      step();
      k = -1;
      for (int i = 0; i < ND; i++) if (bus.anode == ~(ND'(1) << i)) k = i;
      checks++;
      if (k < 0) begin errors++; $display("FAIL scan_onehot: got anode %b expected one low bit", bus.anode); end
      else if (prev >= 0 && k != prev) begin
        checks++;
        if (k != (prev + 1) % ND) begin errors++; $display("FAIL scan_order: got digit %0d after %0d expected %0d", k, prev, (prev + 1) % ND); end
        if (prev == ND - 1 && k == 0) wrapped = 1;
      end
      if (k >= 0) prev = k;
    end
    checks++;
    if (!wrapped) begin errors++; $display("FAIL scan_wrap: got no wrap expected 7->0"); end
  endtask

  task automatic test_overflow();
    show(27'd100000000, 1'b0);
    capture(40);
    e = '{SR, SR, SE, SB, SB, SB, SB, SB};
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL overflow_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
    show(27'd5, 1'b1);
    capture(40);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL oor_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
    show(27'd99999999, 1'b0);
    capture(40);
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== S[9]) begin errors++; $display("FAIL max_digit%0d: got %b expected %b", i, got[i], S[9]); end
    end
  endtask

  task automatic test_lz();
    show(27'd42, 1'b0);
    capture(40);
`ifdef SEG_LZ_BLANK_EN
    e = '{S[2], S[4], SB, SB, SB, SB, SB, SB};
`else
    e = '{S[2], S[4], S[0], S[0], S[0], S[0], S[0], S[0]};
`endif
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL lz42_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
  endtask

  task automatic test_dp();
    bus.dp_mask = 8'b0000_0100;
    show(27'd0, 1'b0);
    capture(40);
`ifdef SEG_LZ_BLANK_EN
    e = '{S[0], SB, 8'hFE, SB, SB, SB, SB, SB};
`else
    e = '{S[0], S[0], 8'b00000010, S[0], S[0], S[0], S[0], S[0]};
`endif
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL dp_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
    bus.dp_mask = 8'b1000_0001;
    show(27'd5, 1'b1);
    capture(40);
    e = '{8'b11110100, SR, SE, SB, SB, SB, SB, 8'hFE};
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL dp_err_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
    bus.dp_mask = '0;
  endtask

  task automatic test_back_to_back();
    int seen = 0;
    bus.out_of_range = 1'b0;
    wait_done();
    bus.in_data = 27'd87654321;
    repeat (5) step();
    bus.in_data = 27'd24681357;
    wait_done();
    capture(28);
    e = '{S[1], S[2], S[3], S[4], S[5], S[6], S[7], S[8]};
    for (int i = 0; i < ND; i++) if (got[i] != 8'h00) begin
      seen++;
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL latched_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
    checks++;
    if (seen < 6) begin errors++; $display("FAIL latched_coverage: got %0d digits expected >=6", seen); end
    wait_done();
    capture(40);
    e = '{S[7], S[5], S[3], S[1], S[8], S[6], S[4], S[2]};
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL next_digit%0d: got %b expected %b", i, got[i], e[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_value();
    test_scan();
    test_overflow();
    test_lz();
    test_dp();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seven_segment_mux_ctrl.md
# seven_segment_mux_ctrl

Parametrised multiplexed seven-segment display controller that converts a binary value to decimal and scans it across NUM_DIGITS common-anode digits. It adds an on-chip sequential binary-to-BCD converter (double-dabble), automatic overflow detection with an "Err" message, per-digit decimal points and optional leading-zero blanking. It sits between datapath result registers and the board's 7-segment pins.

## Interface
- NUM_DIGITS, 8, number of digits scanned; range 3..16
- DATA_W, 27, width of binary input; range 4..64
- DIGIT_PERIOD, 262144, clk cycles each digit stays active; ≥ 2
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- in_data  input  DATA_W  unsigned binary value to display
- out_of_range  input  1  forces the error display
- dp_mask  input  NUM_DIGITS  bit i = 1 lights the decimal point of digit i (digit 0 = rightmost)
- anode  output  NUM_DIGITS  active-low digit enables; bit i drives digit i
- select_seg  output  8  active-low cathodes, bit7..bit0 = a,b,c,d,e,f,g,dp
- conv_done  output  1  one-cycle pulse when a new conversion is committed to the display

## Operation
- Converter FSM, states IDLE, SHIFT, COMMIT:
  - IDLE (1 cycle): latch in_data and out_of_range into shadow registers; clear BCD accumulator (4·NUM_DIGITS+4 bits: NUM_DIGITS digits plus an overflow nibble); go to SHIFT.
  - SHIFT (DATA_W cycles): per cycle, add 3 to every BCD nibble ≥ 5, then shift {bcd, bin} left by 1.
  - COMMIT (1 cycle): err = shadow out_of_range OR overflow nibble ≠ 0; write the digit nibbles and err into the display register; pulse conv_done; go to IDLE.
- Free-running: one conversion every DATA_W+2 cycles. in_data changes during SHIFT affect only the next conversion.
- Scanner: prescaler counts 0..DIGIT_PERIOD-1; on wrap, digit index increments 0..NUM_DIGITS-1 and wraps to 0.
- For active digit i: anode = all ones except bit i = 0.
- Segment encoding: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00001001, blank=11111111, E=01100001, r=11110101.
- When err: digit 2 = E, digit 1 = r, digit 0 = r, all higher digits blank.
- Decimal point: if dp_mask[i], force bit0 of select_seg to 0 for digit i, in every mode including err and blanked digits.

## Timing
- Reset: anode = all ones, select_seg = 8'hFF, conv_done = 0, FSM = IDLE, prescaler = 0, digit index = 0, display register = all-zero digits with err = 0.
- rst mid-conversion aborts it; the partially computed result is never committed.
- anode and select_seg are registered and change together, one cycle after the digit index changes, so the pair is never inconsistent.
- in_data-to-display latency is at most 2·(DATA_W+2) cycles, then visible on the next scan of each digit.
- dp_mask is sampled combinationally into the output register, with 1-cycle latency.
- Boundaries: in_data = 10^NUM_DIGITS − 1 displays normally; 10^NUM_DIGITS sets err. All-ones in_data with DATA_W ≤ 3.32·NUM_DIGITS never sets err.

## Configuration
- SEG_LZ_BLANK_EN defined: digits more significant than the highest nonzero digit show blank. Digit 0 is always shown, so the value 0 displays as a single "0". Error display is unaffected.
- Not defined: all NUM_DIGITS digits are shown with leading zeros.

## Test plan
- Reset held 3 cycles mid-SHIFT, then released → anode = 8'hFF and select_seg = 8'hFF during reset; first conv_done occurs DATA_W+2 cycles after release.
- NUM_DIGITS=8, DATA_W=27, in_data=12345678, DIGIT_PERIOD=4 → digits 7..0 show 1,2,3,4,5,6,7,8; the anode low bit walks 0→7 and wraps.
- in_data = 100000000 (>99999999) → digits 2..0 = E,r,r, digits 7..3 blank. Repeat with in_data=5 and out_of_range=1 → same result.
- in_data=42 with SEG_LZ_BLANK_EN → digits 7..2 = 8'hFF, digit 1 = 10011001, digit 0 = 00100101. Without the macro → digits 7..2 = 00000011.
- dp_mask=8'b0000_0100, in_data=0 → digit 2 shows 00000010, all other digits unchanged.
- in_data changed during SHIFT → the committed value equals the value latched in IDLE; the new value appears at the following conv_done.
